// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the SAP-3 MAR+RAM block.
// Port 0 is the CPU and port 1 is the loader/DMA. Each single-word request
// becomes a MAR load followed by a RAM access. Read data or a write-completion
// pulse is then returned to the requester that owns the transaction.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_load_mar,
  output logic              mem_load_ram,
  output logic [ADDR_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                load_mar_q, load_mar_d;
  logic                load_ram_q, load_ram_d;
  logic [ADDR_W-1:0]   data_in_q, data_in_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                busy_q, busy_d;
  logic                grant;

  // Next-state, arbitration and next registered-output computation.
  // The outputs are derived from the next state, so they line up with the
  // state register after each edge.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) grant = RR_EN ? ~last_q : 1'b0;
          else              grant = req1;
          win_d   = grant;
          owner_d = grant;
          last_d  = grant;
          we_d    = grant ? we1    : we0;
          addr_d  = grant ? addr1  : addr0;
          wdata_d = grant ? wdata1 : wdata0;
          state_d = ADDR;
        end
      end
      ADDR:   state_d = ACCESS;
      ACCESS: begin
        if (!we_q) rdata_d = mem_out;
        state_d = DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    load_mar_d = (state_d == ADDR);
    load_ram_d = (state_d == ACCESS) && we_d;
    data_in_d  = '0;
    if (state_d == ADDR)              data_in_d = addr_d;
    else if (state_d == ACCESS && we_d) data_in_d[DATA_W-1:0] = wdata_d;
    done0_d = (state_d == DONE) && !win_d;
    done1_d = (state_d == DONE) &&  win_d;
    busy_d  = (state_d != IDLE);
  end

  // State, latched request, and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      load_mar_q <= 1'b0;
      load_ram_q <= 1'b0;
      data_in_q  <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      load_mar_q <= load_mar_d;
      load_ram_q <= load_ram_d;
      data_in_q  <= data_in_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  // load_ram is masked by rst so that a reset landing in ACCESS cannot
  // commit the write on that same edge.
  assign mem_load_ram = load_ram_q & ~rst;
  assign mem_load_mar = load_mar_q;
  assign mem_data_in  = data_in_q;
  assign done0        = done0_q;
  assign done1        = done1_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign owner        = owner_q;

endmodule
